// File: rtl/sensor_request_sequencer.sv
// sensor_request_sequencer
// Takes one host request at a time (command + sensor address) and validates it.
// For a good request it drives the sensor address `End` to the demultiplexer,
// lets the select settle, and pulses `sensor_start`. It then waits for the
// reader to finish, fail or time out, and returns a response code plus one
// payload byte. Only one transaction is ever in flight, and nothing is queued.
module sensor_request_sequencer #(
    // Cycles `End` is held before the start strobe; the demux registers its
    // select, so at least 2 are needed.
    parameter int SETTLE_CYCLES  = 4,
    // WAIT cycles without a reader event before a timeout is reported (>= 1).
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    // Host request channel
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_cmd,
    input  logic [7:0]  req_addr,
    // Sensor side
    output logic [7:0]  End,
    output logic        sensor_start,
    input  logic        sensor_done,
    input  logic        sensor_error,
    input  logic [15:0] sensor_data,
    // Host response channel
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_code,
    output logic [7:0]  rsp_data
);

    // ------------------------------------------------------------------
    // Command and response encodings
    // ------------------------------------------------------------------
    localparam logic [7:0] CMD_STATUS   = 8'h01;
    localparam logic [7:0] CMD_TEMP     = 8'h02;
    localparam logic [7:0] CMD_HUMIDITY = 8'h03;

    localparam logic [7:0] RSP_STATUS_OK = 8'h80;
    localparam logic [7:0] RSP_TEMP_OK   = 8'h81;
    localparam logic [7:0] RSP_HUMID_OK  = 8'h82;
    localparam logic [7:0] RSP_BAD_CMD   = 8'hE0;
    localparam logic [7:0] RSP_BAD_ADDR  = 8'hE1;
    localparam logic [7:0] RSP_SENSOR_ER = 8'hE2;
    localparam logic [7:0] RSP_TIMEOUT   = 8'hE3;

    localparam logic [7:0] ADDR_MIN = 8'd1;
    localparam logic [7:0] ADDR_MAX = 8'd32;

    // Terminal counter values. The counters start at 0 on entry to their
    // state, so the last cycle of a phase sees count == N-1.
    localparam logic [31:0] SETTLE_LAST  = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_SELECT  = 3'd2,
        ST_START   = 3'd3,
        ST_WAIT    = 3'd4,
        ST_RESPOND = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t      r_state;
    logic [7:0]  r_cmd;
    logic [7:0]  r_addr;
    logic [7:0]  r_end;
    logic [31:0] r_settle_cnt;
    logic [31:0] r_timeout_cnt;
    logic        r_rsp_valid;
    logic [7:0]  r_rsp_code;
    logic [7:0]  r_rsp_data;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    state_t      w_state_nxt;
    logic        w_accept;
    logic        w_cmd_ok;
    logic        w_addr_ok;
    logic        w_settle_done;
    logic        w_timeout_hit;
    logic        w_load_end;
    logic        w_load_rsp;
    logic        w_rsp_fire;
    logic [7:0]  w_rsp_code_nxt;
    logic [7:0]  w_rsp_data_nxt;

    // While reset is high the state already reads IDLE, so ready is also
    // gated by reset to keep the host from seeing a spurious accept.
    assign req_ready     = (r_state == ST_IDLE) && !reset;
    assign w_accept      = req_valid && req_ready;
    assign w_rsp_fire    = r_rsp_valid && rsp_ready;

    assign w_cmd_ok      = (r_cmd == CMD_STATUS) || (r_cmd == CMD_TEMP) ||
                           (r_cmd == CMD_HUMIDITY);
    assign w_addr_ok     = (r_addr >= ADDR_MIN) && (r_addr <= ADDR_MAX);
    assign w_settle_done = (r_settle_cnt >= SETTLE_LAST);
    assign w_timeout_hit = (r_timeout_cnt >= TIMEOUT_LAST);

    // The strobe is a pure decode of the one-cycle START state, so it cannot
    // be stretched and it drops the instant reset puts the state in IDLE.
    assign sensor_start  = (r_state == ST_START);

    assign End           = r_end;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_code      = r_rsp_code;
    assign rsp_data      = r_rsp_data;

    // State register for the transaction FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // flop samples the pre-edge values regardless of block order.
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic plus the one-cycle load requests for End and the response.
    always_comb begin
        // NOTE: every output of this block gets a default first; any path
        // that skipped an assignment would otherwise infer a latch.
        w_state_nxt    = r_state;
        w_load_end     = 1'b0;
        w_load_rsp     = 1'b0;
        w_rsp_code_nxt = 8'h00;
        w_rsp_data_nxt = 8'h00;

        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_CHECK;
                end
            end

            ST_CHECK: begin
                // A bad command is reported even when the address is also bad.
                if (!w_cmd_ok) begin
                    w_load_rsp     = 1'b1;
                    w_rsp_code_nxt = RSP_BAD_CMD;
                    w_state_nxt    = ST_RESPOND;
                end else if (!w_addr_ok) begin
                    w_load_rsp     = 1'b1;
                    w_rsp_code_nxt = RSP_BAD_ADDR;
                    w_state_nxt    = ST_RESPOND;
                end else begin
                    w_load_end  = 1'b1;
                    w_state_nxt = ST_SELECT;
                end
            end

            ST_SELECT: begin
                if (w_settle_done) begin
                    w_state_nxt = ST_START;
                end
            end

            ST_START: begin
                w_state_nxt = ST_WAIT;
            end

            ST_WAIT: begin
                // Error outranks done, and either event outranks a timeout
                // landing on the same cycle.
                if (sensor_error) begin
                    w_load_rsp     = 1'b1;
                    w_rsp_code_nxt = RSP_SENSOR_ER;
                    w_state_nxt    = ST_RESPOND;
                end else if (sensor_done) begin
                    w_load_rsp  = 1'b1;
                    w_state_nxt = ST_RESPOND;
                    case (r_cmd)
                        CMD_TEMP: begin
                            w_rsp_code_nxt = RSP_TEMP_OK;
                            w_rsp_data_nxt = sensor_data[7:0];
                        end
                        CMD_HUMIDITY: begin
                            w_rsp_code_nxt = RSP_HUMID_OK;
                            w_rsp_data_nxt = sensor_data[15:8];
                        end
                        default: begin
                            w_rsp_code_nxt = RSP_STATUS_OK;
                        end
                    endcase
                end else if (w_timeout_hit) begin
                    w_load_rsp     = 1'b1;
                    w_rsp_code_nxt = RSP_TIMEOUT;
                    w_state_nxt    = ST_RESPOND;
                end
            end

            ST_RESPOND: begin
                if (w_rsp_fire) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request latch: captured only on the accepting handshake, so req_valid
    // traffic in any other state is simply ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cmd  <= 8'h00;
            r_addr <= 8'h00;
        end else if (w_accept) begin
            r_cmd  <= req_cmd;
            r_addr <= req_addr;
        end
    end

    // Sensor address: set for a validated request, cleared on the response
    // handshake; error responses leave it at 0x00.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_end <= 8'h00;
        end else if (w_load_end) begin
            r_end <= r_addr;
        end else if ((r_state == ST_RESPOND) && w_rsp_fire) begin
            r_end <= 8'h00;
        end
    end

    // Settle counter: runs only in SELECT, held at 0 elsewhere, saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_settle_cnt <= 32'd0;
        end else if (r_state == ST_SELECT) begin
            if (r_settle_cnt != '1) begin
                r_settle_cnt <= r_settle_cnt + 32'd1;
            end
        end else begin
            r_settle_cnt <= 32'd0;
        end
    end

    // Timeout counter: cleared through START, counts WAIT cycles, saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timeout_cnt <= 32'd0;
        end else if (r_state == ST_WAIT) begin
            if (r_timeout_cnt != '1) begin
                r_timeout_cnt <= r_timeout_cnt + 32'd1;
            end
        end else begin
            r_timeout_cnt <= 32'd0;
        end
    end

    // Response registers: loaded once per transaction, stable until taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_code  <= 8'h00;
            r_rsp_data  <= 8'h00;
        end else if (w_load_rsp) begin
            r_rsp_valid <= 1'b1;
            r_rsp_code  <= w_rsp_code_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
        end else if (w_rsp_fire) begin
            r_rsp_valid <= 1'b0;
            r_rsp_code  <= 8'h00;
            r_rsp_data  <= 8'h00;
        end
    end

endmodule

// File: tb/tb_sensor_request_sequencer.sv
// Testbench for sensor_request_sequencer: scenario tasks plus randomized
// transactions, all checked against a transaction-level timing/response model.
module tb_sensor_request_sequencer;

    localparam int S  = 4;  // settle cycles
    localparam int TO = 8;  // timeout cycles

    // Reader behaviour for one transaction
    localparam int K_DONE  = 0;
    localparam int K_ERROR = 1;
    localparam int K_BOTH  = 2;
    localparam int K_NONE  = 3;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_cmd;
    logic [7:0]  req_addr;
    logic [7:0]  End;
    logic        sensor_start;
    logic        sensor_done;
    logic        sensor_error;
    logic [15:0] sensor_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_code;
    logic [7:0]  rsp_data;

    int checks = 0;
    int errors = 0;

    sensor_request_sequencer #(
        .SETTLE_CYCLES (S),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_cmd     (req_cmd),
        .req_addr    (req_addr),
        .End         (End),
        .sensor_start(sensor_start),
        .sensor_done (sensor_done),
        .sensor_error(sensor_error),
        .sensor_data (sensor_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_code    (rsp_code),
        .rsp_data    (rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so a stuck design can never hang the run.
    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    // Transaction-level model. Timing is expressed as the index n of the
    // falling edge (n=0 is the first falling edge after the accepting rising
    // edge) at which rsp_valid is first seen. Reader event d counts cycles
    // after the sensor_start cycle (d=1 is the first WAIT cycle).
    function automatic void model(input logic [7:0] cmd, input logic [7:0] addr,
                                  input int kind, input int d, input logic [15:0] data,
                                  output logic [7:0] code, output logic [7:0] payload,
                                  output int n_rsp, output bit selects);
        selects = 1'b0;
        payload = 8'h00;
        if (!(cmd == 8'h01 || cmd == 8'h02 || cmd == 8'h03)) begin
            code  = 8'hE0;
            n_rsp = 1;
        end else if (addr < 8'd1 || addr > 8'd32) begin
            code  = 8'hE1;
            n_rsp = 1;
        end else begin
            selects = 1'b1;
            if (kind == K_NONE || d > TO) begin
                code  = 8'hE3;
                n_rsp = 2 + S + TO;
            end else begin
                n_rsp = 2 + S + d;
                if (kind != K_DONE) begin
                    code = 8'hE2;
                end else if (cmd == 8'h01) begin
                    code = 8'h80;
                end else if (cmd == 8'h02) begin
                    code    = 8'h81;
                    payload = data[7:0];
                end else begin
                    code    = 8'h82;
                    payload = data[15:8];
                end
            end
        end
    endfunction

    // One complete transaction starting and ending on a falling edge with
    // the DUT idle. hold = cycles rsp_ready stays low once the response is up;
    // noise = spurious reader events before WAIT and junk on the request bus
    // while busy.
    task automatic run_txn(input logic [7:0] cmd, input logic [7:0] addr, input int kind,
                           input int d, input logic [15:0] data, input int hold, input bit noise);
        logic [7:0] e_code;
        logic [7:0] e_data;
        logic [7:0] e_end;
        logic       e_start;
        logic       e_valid;
        int         n_rsp;
        bit         sel;
        bit         fire;
        model(cmd, addr, kind, d, data, e_code, e_data, n_rsp, sel);
        e_end = 8'h00;

        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready cmd=%h addr=%0d: got %b want 1", cmd, addr, req_ready);
        end
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_addr  = addr;

        for (int n = 0; n <= n_rsp; n++) begin
            @(negedge clk);
            e_end   = (sel && n >= 1) ? addr : 8'h00;
            e_start = (sel && n == 1 + S) ? 1'b1 : 1'b0;
            e_valid = (n == n_rsp) ? 1'b1 : 1'b0;
            checks++;
            if (End !== e_end) begin
                errors++;
                $display("FAIL end n=%0d cmd=%h addr=%0d: got %h want %h", n, cmd, addr, End, e_end);
            end
            checks++;
            if (sensor_start !== e_start) begin
                errors++;
                $display("FAIL start n=%0d cmd=%h addr=%0d: got %b want %b", n, cmd, addr, sensor_start, e_start);
            end
            checks++;
            if (rsp_valid !== e_valid) begin
                errors++;
                $display("FAIL rsp_valid n=%0d cmd=%h addr=%0d: got %b want %b", n, cmd, addr, rsp_valid, e_valid);
            end
            checks++;
            if (req_ready !== 1'b0) begin
                errors++;
                $display("FAIL busy_ready n=%0d: got %b want 0", n, req_ready);
            end
            if (n == n_rsp) begin
                checks++;
                if (rsp_code !== e_code) begin
                    errors++;
                    $display("FAIL rsp_code cmd=%h addr=%0d kind=%0d d=%0d: got %h want %h", cmd, addr, kind, d, rsp_code, e_code);
                end
                checks++;
                if (rsp_data !== e_data) begin
                    errors++;
                    $display("FAIL rsp_data cmd=%h addr=%0d kind=%0d d=%0d: got %h want %h", cmd, addr, kind, d, rsp_data, e_data);
                end
            end

            // Drive this cycle's reader and request inputs.
            sensor_done  = 1'b0;
            sensor_error = 1'b0;
            sensor_data  = 16'($urandom);
            fire = sel && (kind != K_NONE) && (d <= TO) && (n == 1 + S + d);
            if (fire) begin
                sensor_data  = data;
                sensor_done  = (kind == K_DONE || kind == K_BOTH);
                sensor_error = (kind == K_ERROR || kind == K_BOTH);
            end else if (noise && n <= 1 + S) begin
                sensor_done  = 1'($urandom_range(0, 1));
                sensor_error = 1'($urandom_range(0, 1));
            end
            if (noise) begin
                req_valid = 1'($urandom_range(0, 1));
                req_cmd   = 8'($urandom);
                req_addr  = 8'($urandom);
            end else begin
                req_valid = 1'b0;
            end
        end

        sensor_done  = 1'b0;
        sensor_error = 1'b0;
        for (int h = 0; h < hold; h++) begin
            rsp_ready = 1'b0;
            req_valid = 1'b1;
            req_cmd   = 8'h02;
            req_addr  = 8'd3;
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_code !== e_code || rsp_data !== e_data) begin
                errors++;
                $display("FAIL hold_rsp h=%0d: got v=%b code=%h data=%h want v=1 code=%h data=%h",
                         h, rsp_valid, rsp_code, rsp_data, e_code, e_data);
            end
            checks++;
            if (End !== e_end || req_ready !== 1'b0 || sensor_start !== 1'b0) begin
                errors++;
                $display("FAIL hold_side h=%0d: got end=%h ready=%b start=%b want end=%h ready=0 start=0",
                         h, End, req_ready, sensor_start, e_end);
            end
        end

        rsp_ready = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_code !== 8'h00 || rsp_data !== 8'h00) begin
            errors++;
            $display("FAIL post_rsp: got v=%b code=%h data=%h want v=0 code=00 data=00", rsp_valid, rsp_code, rsp_data);
        end
        checks++;
        if (End !== 8'h00 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_idle: got end=%h ready=%b want end=00 ready=1", End, req_ready);
        end
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_cmd      = 8'h00;
        req_addr     = 8'h00;
        sensor_done  = 1'b0;
        sensor_error = 1'b0;
        sensor_data  = 16'h0000;
        rsp_ready    = 1'b0;
        #22;
        checks++;
        if (End !== 8'h00 || sensor_start !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got end=%h start=%b v=%b want 00/0/0", End, sensor_start, rsp_valid);
        end
        checks++;
        if (rsp_code !== 8'h00 || rsp_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_rsp: got code=%h data=%h want 00/00", rsp_code, rsp_data);
        end
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b want 0", req_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_temperature();
        run_txn(8'h02, 8'd5, K_DONE, 3, 16'h3719, 0, 1'b0);
    endtask

    task automatic test_humidity_and_range();
        run_txn(8'h03, 8'd32, K_DONE, 3, 16'h3719, 0, 1'b0);
        run_txn(8'h02, 8'd0, K_DONE, 3, 16'h3719, 0, 1'b0);
        run_txn(8'h01, 8'd33, K_DONE, 3, 16'h3719, 0, 1'b0);
        run_txn(8'h01, 8'd1, K_DONE, 1, 16'hBEEF, 0, 1'b0);
    endtask

    task automatic test_cmd_priority();
        run_txn(8'h07, 8'd40, K_DONE, 3, 16'h3719, 0, 1'b0);
        run_txn(8'h00, 8'd10, K_DONE, 3, 16'h3719, 0, 1'b0);
    endtask

    task automatic test_timeout_and_priority();
        run_txn(8'h01, 8'd7, K_NONE, 0, 16'h0000, 0, 1'b0);
        run_txn(8'h02, 8'd12, K_DONE, TO, 16'hA55A, 0, 1'b0);
        run_txn(8'h03, 8'd1, K_BOTH, 2, 16'h4321, 0, 1'b0);
        run_txn(8'h01, 8'd20, K_ERROR, TO, 16'h1111, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_txn(8'h02, 8'd17, K_DONE, 2, 16'h1234, 10, 1'b0);
        run_txn(8'h03, 8'd3, K_DONE, 1, 16'h9A00, 0, 1'b0);
        run_txn(8'h02, 8'd4, K_DONE, 5, 16'h00C3, 0, 1'b1);
    endtask

    // Reset asserted between clock edges at falling-edge index n_at of a valid
    // transaction; End and the strobe must drop at once and no response follows.
    task automatic test_reset_mid(input int n_at);
        req_valid = 1'b1;
        req_cmd   = 8'h02;
        req_addr  = 8'd9;
        for (int n = 0; n <= n_at; n++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        checks++;
        if (End !== 8'd9 || sensor_start !== ((n_at == 1 + S) ? 1'b1 : 1'b0)) begin
            errors++;
            $display("FAIL pre_reset n=%0d: got end=%h start=%b", n_at, End, sensor_start);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (End !== 8'h00 || sensor_start !== 1'b0 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset n=%0d: got end=%h start=%b ready=%b v=%b want 00/0/0/0",
                     n_at, End, sensor_start, req_ready, rsp_valid);
        end
        @(negedge clk);
        reset     = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || End !== 8'h00 || sensor_start !== 1'b0) begin
                errors++;
                $display("FAIL after_reset i=%0d: got v=%b end=%h start=%b want 0/00/0", i, rsp_valid, End, sensor_start);
            end
        end
        rsp_ready = 1'b0;
        run_txn(8'h03, 8'd30, K_DONE, 4, 16'h5566, 0, 1'b0);
    endtask

    task automatic test_random(input int count);
        logic [7:0]  cmd;
        logic [7:0]  addr;
        logic [15:0] data;
        for (int t = 0; t < count; t++) begin
            cmd  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(1, 3));
            addr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(1, 32));
            data = 16'($urandom);
            run_txn(cmd, addr, int'($urandom_range(0, 3)), int'($urandom_range(1, TO + 2)),
                    data, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_temperature();
        test_humidity_and_range();
        test_cmd_priority();
        test_timeout_and_priority();
        test_back_to_back();
        test_reset_mid(1 + S + 2);
        test_reset_mid(1 + S);
        test_random(60);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
